instr_mem_receiver: RTL and testbench
=====================================

# instr_mem_receiver

Receiving end of the instruction-load write stream: it accepts sequential 16-bit instruction words from the loader over a write-address/write-data/write-enable port, stores them in an internal program RAM and checks ordering. Once the stream completes it releases the processor core and serves instruction fetches. It sits between `instr_load_counter` and the processor core, replacing a bare RAM on the processor side.

## Interface
- `ADDR_W`, 9, word-address width
- `DATA_W`, 16, instruction width
- `DEPTH`, 512, program RAM words (2**ADDR_W)

Ports:
- `clk_in`  in  1  single clock, all logic on rising edge
- `rst_load`  in  1  reset, synchronous, active-low
- `wr_en`  in  1  write strobe from loader, one word per cycle
- `wr_addr`  in  ADDR_W  write word address
- `wr_data`  in  DATA_W  instruction word
- `wr_last`  in  1  qualifies the final word of the stream (valid only with `wr_en`)
- `fetch_en`  in  1  core fetch request
- `fetch_addr`  in  ADDR_W  core program counter
- `instr`  out  DATA_W  fetched instruction, registered
- `load_done`  out  1  program loaded and valid
- `cpu_rst`  out  1  active-high hold of the core; equals `~load_done`
- `load_err`  out  1  sticky ordering error
- `word_count`  out  ADDR_W+1  words accepted
- `checksum`  out  DATA_W  running XOR of accepted words (see Configuration)

## Operation
- States: IDLE, LOAD, DONE, ERR. Encoding is free; only behaviour is specified.
- Reset (`rst_load`=0 at an edge): state IDLE, `word_count`=0, `instr`=0, `load_done`=0, `cpu_rst`=1, `load_err`=0, `checksum`=0. RAM contents are not cleared.
- IDLE, `wr_en`=1 with `wr_addr`=0: write the word, `word_count`=1, go to LOAD, or to DONE if `wr_last`=1.
- IDLE, `wr_en`=1 with `wr_addr`≠0: no write, go to ERR.
- LOAD, `wr_en`=1 with `wr_addr`==`word_count[ADDR_W-1:0]`: write the word and increment `word_count`. Go to DONE if `wr_last`=1 or `wr_addr`==DEPTH-1 (RAM full).
- LOAD, `wr_en`=1 with an address mismatch: no write, go to ERR.
- LOAD, `wr_en`=0: hold. Gaps of any length are legal.
- DONE: `load_done`=1, `cpu_rst`=0. All writes are ignored, and `word_count` and `checksum` are frozen.
- ERR: `load_err`=1, `load_done`=0, `cpu_rst`=1. All writes are ignored. The only exit is reset.
- Fetch in DONE: `instr` <= RAM[`fetch_addr`] when `fetch_en`=1; `instr` holds when `fetch_en`=0.
- Fetch in any other state: `instr` <= 0 (NOP).
- `fetch_addr` beyond `word_count` returns stale or undefined RAM data. No check is made.

## Timing
- A write is committed on the edge that samples `wr_en`=1. `word_count` and `checksum` reflect it after that edge.
- `load_done` rises on the edge that accepts the last or full word. `cpu_rst` falls on the same edge.
- Fetch latency is 1 cycle: address at edge N, `instr` valid after edge N.
- The first fetch can be issued in the cycle after `load_done` rises.
- Reset mid-load: takes effect on the next edge and overrides a simultaneous `wr_en`. The partial RAM image is kept but unusable until a fresh stream from address 0 completes.
- `wr_en` and `fetch_en` in the same cycle during LOAD: the write proceeds and `instr` <= 0.

## Configuration
- `CHECKSUM_EN` defined: `checksum` <= `checksum` ^ `wr_data` on every accepted write. It is frozen in DONE and ERR and cleared by reset.
- `CHECKSUM_EN` undefined: `checksum` is tied to 0 and no accumulator register is built.

## Test plan
- Reset, then write 0x1111, 0x2222 and 0x4444 at addresses 0..2 with `wr_last` on the third -> `load_done`=1 and `cpu_rst`=0 after the third edge, `word_count`=3, `checksum`=0x7777 (0 without the macro). Fetch at address 1 -> `instr`=0x2222 one cycle later.
- First write at `wr_addr`=5 -> `load_err`=1, `load_done`=0, `cpu_rst`=1, `word_count`=0. Writes at address 0 after this are ignored.
- Write addresses 0, 1, 3 -> ERR on the third write, `word_count`=2. Words at 0 and 1 remain in RAM.
- 512 sequential writes with no `wr_last` -> DONE after the write at address 511, `word_count`=512. A further write of 0xFFFF to address 0 is ignored and a fetch at 0 returns the original word.
- `fetch_en`=1 during LOAD -> `instr`=0. Write gaps of 3 idle cycles mid-stream -> load still completes.
- Drive `rst_load`=0 after 2 of 4 words -> state IDLE, `word_count`=0, `cpu_rst`=1. A fresh 4-word stream from 0 then completes with `word_count`=4.

Source files
------------

// File: rtl/instr_mem_receiver.sv
// Receiving end of the instruction-load write stream: stores ordered words in program RAM,
// releases the core when loading completes and serves fetches. Macro CHECKSUM_EN adds the XOR checksum.
module instr_mem_receiver #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic              clk_in,
  input  logic              rst_load,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              load_done,
  output logic              cpu_rst,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              addr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign addr_ok = (wr_addr == word_count[ADDR_W-1:0]);

  // A word is accepted only when it continues the stream in order; anything else is fatal.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          if (wr_addr == '0) begin
            accept     = 1'b1;
            state_next = wr_last ? DONE : LOAD;
          end else begin
            state_next = ERR;
          end
        end
      end
      LOAD: begin
        if (wr_en) begin
          if (addr_ok) begin
            accept = 1'b1;
            if (wr_last || wr_addr == LAST_ADDR) begin
              state_next = DONE;
            end
          end else begin
            state_next = ERR;
          end
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_load) begin
      state      <= IDLE;
      word_count <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word_count <= word_count + (ADDR_W + 1)'(1);
      end
    end
  end

  // Program RAM is never cleared; reset only blocks a write in the same cycle.
  always_ff @(posedge clk_in) begin
    if (rst_load && accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_load) begin
      instr <= '0;
    end else if (state != DONE) begin
      instr <= '0;
    end else if (fetch_en) begin
      instr <= mem[fetch_addr];
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk_in) begin
    if (!rst_load) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum ^ wr_data;
    end
  end
`else
  assign checksum = '0;
`endif

  assign load_done = (state == DONE);
  assign cpu_rst   = ~load_done;
  assign load_err  = (state == ERR);

endmodule

// File: tb/tb_instr_mem_receiver.sv
// Self-checking bench for instr_mem_receiver: directed vector table, hand sequences for
// the long/multi-cycle cases, and randomized traffic against a stream-level reference model.
module tb_instr_mem_receiver;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;

  logic              clk_in = 1'b0;
  logic              rst_load;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instr;
  logic              load_done;
  logic              cpu_rst;
  logic              load_err;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] checksum;

  instr_mem_receiver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_load(rst_load), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr(instr), .load_done(load_done), .cpu_rst(cpu_rst), .load_err(load_err),
    .word_count(word_count), .checksum(checksum)
  );

  always #5 clk_in = ~clk_in;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the stream is a count of words received in order; RAM persists across reset.
  logic [DATA_W-1:0] m_mem   [DEPTH];
  bit                m_valid [DEPTH];
  int                m_count = 0;
  bit                m_done  = 0;
  bit                m_err   = 0;
  logic [DATA_W-1:0] m_csum  = '0;
  logic [DATA_W-1:0] m_instr = '0;
  bit                m_instr_known = 0;

  typedef struct {
    bit          rst;
    bit          we;
    int          addr;
    int          data;
    bit          last;
    bit          fe;
    int          faddr;
    bit          exp_done;
    bit          exp_err;
    int          exp_count;
    int          exp_csum;
    bit          chk_instr;
    int          exp_instr;
  } vector_t;

  vector_t tbl[$];

  function automatic int csum_view(input int v);
`ifdef CHECKSUM_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic vector_t mk(input bit rst, input bit we, input int addr, input int data,
                                 input bit last, input bit fe, input int faddr,
                                 input bit exp_done, input bit exp_err, input int exp_count,
                                 input int exp_csum, input bit chk_instr, input int exp_instr);
    vector_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.data = data; v.last = last;
    v.fe = fe; v.faddr = faddr; v.exp_done = exp_done; v.exp_err = exp_err;
    v.exp_count = exp_count; v.exp_csum = exp_csum; v.chk_instr = chk_instr;
    v.exp_instr = exp_instr;
    return v;
  endfunction

  task automatic model_step();
    if (!rst_load) begin
      m_count = 0; m_done = 0; m_err = 0; m_csum = '0;
      m_instr = '0; m_instr_known = 1;
    end else begin
      if (m_done) begin
        if (fetch_en) begin
          m_instr_known = m_valid[fetch_addr];
          m_instr       = m_mem[fetch_addr];
        end
      end else begin
        m_instr = '0; m_instr_known = 1;
      end
      if (wr_en && !m_done && !m_err) begin
        if (int'(wr_addr) == m_count) begin
          m_mem[wr_addr]   = wr_data;
          m_valid[wr_addr] = 1;
          m_count++;
          m_csum ^= wr_data;
          if (wr_last || m_count == DEPTH) m_done = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic compare_field(input string name, input string field, input int got, input int exp);
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: %s got 0x%0h expected 0x%0h", name, field, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model and settle past the edge.
  task automatic applyStimulus(input bit rst, input bit we, input int addr, input int data,
                               input bit last, input bit fe, input int faddr);
    rst_load   = rst;
    wr_en      = we;
    wr_addr    = ADDR_W'(addr);
    wr_data    = DATA_W'(data);
    wr_last    = last;
    fetch_en   = fe;
    fetch_addr = ADDR_W'(faddr);
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic checkOutput(input string name);
    vectors++;
    compare_field(name, "load_done", int'(load_done), int'(m_done));
    compare_field(name, "cpu_rst", int'(cpu_rst), int'(!m_done));
    compare_field(name, "load_err", int'(load_err), int'(m_err));
    compare_field(name, "word_count", int'(word_count), m_count);
    compare_field(name, "checksum", int'(checksum), csum_view(int'(m_csum)));
    if (m_instr_known) compare_field(name, "instr", int'(instr), int'(m_instr));
  endtask

  task automatic check_vector(input int idx, input vector_t v);
    string name;
    name = $sformatf("table[%0d]", idx);
    vectors++;
    compare_field(name, "load_done", int'(load_done), int'(v.exp_done));
    compare_field(name, "cpu_rst", int'(cpu_rst), int'(!v.exp_done));
    compare_field(name, "load_err", int'(load_err), int'(v.exp_err));
    compare_field(name, "word_count", int'(word_count), v.exp_count);
    compare_field(name, "checksum", int'(checksum), csum_view(v.exp_csum));
    if (v.chk_instr) compare_field(name, "instr", int'(instr), v.exp_instr);
  endtask

  initial begin
    rst_load = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    wr_last = 0; fetch_en = 0; fetch_addr = '0;

    //                 rst we addr data  last fe fa  done err cnt csum    chk instr
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,   0, 0, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 'h1111, 0, 0, 0,   0, 0, 1, 16'h1111, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 1, 'h2222, 0, 0, 0,   0, 0, 2, 16'h3333, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 2, 'h4444, 1, 0, 0,   1, 0, 3, 16'h7777, 1, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,      0, 1, 1,   1, 0, 3, 16'h7777, 1, 16'h2222));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,   1, 0, 3, 16'h7777, 1, 16'h2222));
    tbl.push_back(mk(1, 0, 0, 0,      0, 1, 0,   1, 0, 3, 16'h7777, 1, 16'h1111));
    tbl.push_back(mk(1, 1, 3, 'h5555, 1, 1, 2,   1, 0, 3, 16'h7777, 1, 16'h4444));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,   0, 0, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 5, 'h1234, 0, 0, 0,   0, 1, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 'h9999, 1, 1, 0,   0, 1, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,   0, 0, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 'hAAAA, 0, 0, 0,   0, 0, 1, 16'hAAAA, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 1, 'hBBBB, 0, 0, 0,   0, 0, 2, 16'h1111, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 3, 'hCCCC, 0, 0, 0,   0, 1, 2, 16'h1111, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,   0, 0, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 'hAAAA, 1, 0, 0,   1, 0, 1, 16'hAAAA, 1, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0,      0, 1, 1,   1, 0, 1, 16'hAAAA, 1, 16'hBBBB));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].we, tbl[i].addr, tbl[i].data,
                    tbl[i].last, tbl[i].fe, tbl[i].faddr);
      check_vector(i, tbl[i]);
    end

    $display("[TB] full-depth load");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_reset");
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1, 1, a, int'($urandom_range(16'hFFFF)), 0, 0, 0);
      checkOutput("full_write");
    end
    vectors++;
    compare_field("full_count", "word_count", int'(word_count), DEPTH);
    compare_field("full_count", "load_done", int'(load_done), 1);
    applyStimulus(1, 1, 0, 'hFFFF, 0, 1, 0);
    checkOutput("full_ignore_write");
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    checkOutput("full_fetch0");
    applyStimulus(1, 0, 0, 0, 0, 1, DEPTH - 1);
    checkOutput("full_fetch_top");

    $display("[TB] gaps and fetch during load");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("gap_reset");
    applyStimulus(1, 1, 0, 'h0101, 0, 1, 0);
    checkOutput("gap_w0");
    applyStimulus(1, 1, 1, 'h0202, 0, 1, 1);
    checkOutput("gap_w1");
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, g);
      checkOutput("gap_idle");
      vectors++;
      compare_field("gap_idle_nop", "instr", int'(instr), 0);
    end
    applyStimulus(1, 1, 2, 'h0303, 0, 1, 0);
    checkOutput("gap_w2");
    applyStimulus(1, 1, 3, 'h0404, 1, 0, 0);
    checkOutput("gap_w3_last");
    applyStimulus(1, 0, 0, 0, 0, 1, 2);
    checkOutput("gap_fetch2");

    $display("[TB] reset mid-load");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 'h1010, 0, 0, 0);
    applyStimulus(1, 1, 1, 'h2020, 0, 0, 0);
    checkOutput("mid_two_words");
    applyStimulus(0, 1, 2, 'h3030, 0, 0, 0);
    checkOutput("mid_reset_over_write");
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1, 1, a, 'h5000 + a, (a == 3), 0, 0);
      checkOutput("mid_fresh_stream");
    end
    vectors++;
    compare_field("mid_fresh_count", "word_count", int'(word_count), 4);
    applyStimulus(1, 0, 0, 0, 0, 1, 3);
    checkOutput("mid_fetch3");

    $display("[TB] randomized traffic");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit rst_r, we_r, last_r, fe_r;
      int addr_r, faddr_r;
      rst_r  = ($urandom_range(99) >= 2);
      we_r   = ($urandom_range(99) < 70);
      addr_r = ($urandom_range(99) < 3) ? int'($urandom_range(DEPTH - 1)) : (m_count % DEPTH);
      last_r = ($urandom_range(99) < 4);
      fe_r   = ($urandom_range(99) < 50);
      faddr_r = (m_count > 0) ? int'($urandom_range(m_count - 1)) : int'($urandom_range(DEPTH - 1));
      applyStimulus(rst_r, we_r, addr_r, int'($urandom_range(16'hFFFF)), last_r, fe_r, faddr_r);
      checkOutput("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
